lane_vrf_write_arbiter: RTL
===========================

# lane_vrf_write_arbiter

Per-lane arbiter merging the VRF write requests of the lane's execution slots into the lane's single VRF write port. It sits directly downstream of each slot's stage-3 write queue and consumes its `vrfWriteRequest` ready/valid stream. It arbitrates round-robin, drops empty-mask beats, and registers the winner into a one-entry output stage. It also pulses a retire indication when an instruction's final write reaches the VRF.

## Interface
Parameters:
- `SLOTS`, 4: number of requesting slots (≥2)
- `VD_W`, 5: VRF register index width
- `DATA_W`, 32: write data width
- `MASK_W`, 4: byte-enable width (`DATA_W/8`)
- `IDX_W`, 3: instruction index width

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clock`, in, 1: clock.
  - `reset`, in, 1: synchronous reset, active-low; sampled on rising `clock`, asserted when 0.
- `req_valid`, in, SLOTS: per-slot request valid.
- `req_ready`, out, SLOTS: per-slot accept.
- `req_vd`, in, SLOTS*VD_W: packed; slot i at `[i*VD_W +: VD_W]`.
- `req_mask`, in, SLOTS*MASK_W: packed byte enables.
- `req_data`, in, SLOTS*DATA_W: packed write data.
- `req_last`, in, SLOTS: final write of instruction from that slot.
- `req_instructionIndex`, in, SLOTS*IDX_W: packed instruction index.
- `vrfWrite_valid`, out, 1: output beat valid.
- `vrfWrite_ready`, in, 1: VRF accepts beat.
- `vrfWrite_bits_vd`, `_mask`, `_data`, `_last`, `_instructionIndex`, out, VD_W/MASK_W/DATA_W/1/IDX_W: registered winner fields.
- `vrfWrite_slot`, out, log2(SLOTS): source slot of current beat.
- `retire_valid`, out, 1: one-cycle pulse, last beat written.
- `retire_instructionIndex`, out, IDX_W: index of retired instruction.

## Operation
- **Output register:** one entry (`full`, fields). `canLoad = ~full | vrfWrite_ready`.
- **Eligibility:** slot i is eligible when `req_valid[i]`.
- **Arbitration:** round-robin pointer `rr`. Grant goes to the first eligible slot at or after `rr`, wrapping from SLOTS-1 to 0. At most one grant per cycle.
- **Handshake:** `req_ready[i] = grant[i] & canLoad`. `req_ready` never depends on other slots' data, only on valids, `rr`, `full` and `vrfWrite_ready`.
- **Accept, non-empty beat:** on accept (`req_valid[i] & req_ready[i]`) with `req_mask != 0` or `req_last == 1`, load the output register with the fields and `vrfWrite_slot = i`; set `full = 1`.
- **Accept, empty beat:** on accept with `req_mask == 0` and `req_last == 0`, consume the beat without loading; `full` follows the dequeue only.
- **Pointer update:** on any accept, `rr <= (i+1) mod SLOTS`. With no accept, `rr` holds.
- **Dequeue:** when `full & vrfWrite_ready`, clear `full` unless reloaded the same cycle, which gives back-to-back throughput of 1 beat/cycle.
- **Retire:**
  - On dequeue with `bits_last == 1`, `retire_valid <= 1` next cycle and `retire_instructionIndex <= bits_instructionIndex`.
  - Otherwise `retire_valid <= 0`.
  - A last beat with zero mask is still forwarded so retire is never lost; the VRF treats mask 0 as no-op.
- **Fairness:** with K continuously valid slots, each is granted once per K accepts.

## Timing
- Reset (`reset == 0` at an edge):
  - `full = 0`, `vrfWrite_valid = 0`, `rr = 0`.
  - `retire_valid = 0`; `retire_instructionIndex = 0`, `vrfWrite_slot = 0`, and all `vrfWrite_bits_* = 0`.
  - `req_ready` is all 0 during reset.
  - Reset mid-operation discards the held beat with no retire pulse.
- Latency: accepted beat appears on `vrfWrite_*` the cycle after accept. Retire pulses the cycle after the VRF handshake.
- `vrfWrite_*` fields are stable while `vrfWrite_valid & ~vrfWrite_ready`.
- Output stalled and full: all `req_ready = 0`; `rr` holds.
- Simultaneous dequeue and load: legal; new data replaces, `full` stays 1.
- Dropped empty beat while full and stalled: not possible, since `canLoad = 0` applies to drops too.
- `vrfWrite_valid = full`, combinationally.

## Structure
- **Shared lane package:** `vrf_write_req_t` struct (vd, mask, data, last, instructionIndex) parameterised from the lane-wide VD/DATA/MASK/IDX width constants; reuse the existing lane width constants, no new ones.
- **Sub-module:** `rr_arbiter` (SLOTS-wide, inputs `req`/`advance`, outputs one-hot `grant`/`grant_idx`, internal pointer). It is reusable by the read-port arbiters.
- **Top level:** the output register, drop logic and retire pulse live in the top module.

## Test plan
1. **Reset:** hold `reset = 0` for 3 cycles with all `req_valid = 1` → `req_ready = 0`, `vrfWrite_valid = 0`, `retire_valid = 0`. First cycle after release: slot 0 granted.
2. **Round-robin:** all 4 slots valid continuously, `vrfWrite_ready = 1` → `vrfWrite_slot` sequence 0,1,2,3,0, one beat per cycle, data matches the per-slot pattern `32'hA0+i`.
3. **Backpressure:**
   - Slot 2 sends vd = 5, mask = 4'hF, data = 32'hDEADBEEF; hold `vrfWrite_ready = 0` for 4 cycles → output held stable, all `req_ready = 0`, `rr` unchanged.
   - Release `vrfWrite_ready` → the beat drains, and the next winner is slot 3 if valid.
4. **Empty-mask drop:** slot 1 sends mask = 0, last = 0 → `req_ready[1] = 1`, no `vrfWrite_valid`. Then slot 1 sends mask = 0, last = 1, instructionIndex = 6 → beat forwarded and `retire_valid` pulses with index 6.
5. **Retire timing:** slot 0 sends last = 1, index = 3, accepted at cycle t with `vrfWrite_ready = 1` → `vrfWrite_valid` at t+1, `retire_valid = 1`, index 3 at t+2, for exactly one cycle.
6. **Reset mid-stall:** load a beat with last = 1, stall the output, assert reset → after reset `vrfWrite_valid = 0` and `retire_valid` never pulses.

Source files
------------

// File: rtl/lane_vrf_write_arbiter_pkg.sv
// lane_vrf_write_arbiter_pkg: lane-wide VRF width constants and the write request record.
package lane_vrf_write_arbiter_pkg;

   localparam int LANE_VD_W   = 5;
   localparam int LANE_DATA_W = 32;
   localparam int LANE_MASK_W = LANE_DATA_W / 8;
   localparam int LANE_IDX_W  = 3;

   typedef struct packed {
      logic [LANE_VD_W-1:0]   vd;
      logic [LANE_MASK_W-1:0] mask;
      logic [LANE_DATA_W-1:0] data;
      logic                   last;
      logic [LANE_IDX_W-1:0]  instructionIndex;
   } vrf_write_req_t;

endpackage

// File: rtl/lane_vrf_write_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant to the first requester at or after the pointer.
// The pointer moves past the winner only when the caller reports an accept.
module rr_arbiter #(
   parameter  int SLOTS = 4,
   localparam int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [SLOTS-1:0] req,
   input  logic             advance,
   output logic [SLOTS-1:0] grant,
   output logic [IW-1:0]    grant_idx
);

   logic [IW-1:0] rr_q, rr_d;
   logic [IW:0]   cand;
   logic          found;

   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < SLOTS; k++) begin
         cand = {1'b0, rr_q} + (IW+1)'(k);
         cand = (cand >= (IW+1)'(SLOTS)) ? cand - (IW+1)'(SLOTS) : cand;
         if (!found && req[cand[IW-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[IW-1:0];
         end
      end
      grant = found ? (SLOTS'(1) << grant_idx) : '0;
      rr_d  = advance ? ((grant_idx == IW'(SLOTS-1)) ? '0 : grant_idx + 1'b1) : rr_q;
   end

   always_ff @(posedge clock) begin
      if (!reset) rr_q <= '0;
      else        rr_q <= rr_d;
   end

endmodule

// File: rtl/lane_vrf_write_arbiter.sv
// lane_vrf_write_arbiter: merges per-slot VRF write streams into one registered write port,
// dropping empty non-last beats and pulsing retire when a last beat is written.
module lane_vrf_write_arbiter
   import lane_vrf_write_arbiter_pkg::*;
#(
   parameter  int SLOTS  = 4,
   parameter  int VD_W   = LANE_VD_W,
   parameter  int DATA_W = LANE_DATA_W,
   parameter  int MASK_W = LANE_MASK_W,
   parameter  int IDX_W  = LANE_IDX_W,
   localparam int SW     = $clog2(SLOTS)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [SLOTS-1:0]        req_valid,
   output logic [SLOTS-1:0]        req_ready,
   input  logic [SLOTS*VD_W-1:0]   req_vd,
   input  logic [SLOTS*MASK_W-1:0] req_mask,
   input  logic [SLOTS*DATA_W-1:0] req_data,
   input  logic [SLOTS-1:0]        req_last,
   input  logic [SLOTS*IDX_W-1:0]  req_instructionIndex,
   output logic                    vrfWrite_valid,
   input  logic                    vrfWrite_ready,
   output logic [VD_W-1:0]         vrfWrite_bits_vd,
   output logic [MASK_W-1:0]       vrfWrite_bits_mask,
   output logic [DATA_W-1:0]       vrfWrite_bits_data,
   output logic                    vrfWrite_bits_last,
   output logic [IDX_W-1:0]        vrfWrite_bits_instructionIndex,
   output logic [SW-1:0]           vrfWrite_slot,
   output logic                    retire_valid,
   output logic [IDX_W-1:0]        retire_instructionIndex
);

   vrf_write_req_t   sel, bits_q, bits_d;
   logic             full_q, full_d, retire_q, retire_d;
   logic [SW-1:0]    slot_q, slot_d, grant_idx;
   logic [IDX_W-1:0] ret_idx_q, ret_idx_d;
   logic [SLOTS-1:0] grant;
   logic             can_load, accept, load, deq;

   rr_arbiter #(.SLOTS(SLOTS)) u_arb (
      .clock     (clock),
      .reset     (reset),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Ready is gated by reset so no slot sees an accept while the block is held in reset.
   assign can_load  = ~full_q | vrfWrite_ready;
   assign req_ready = grant & {SLOTS{can_load & reset}};
   assign accept    = |req_ready;

   always_comb begin
      sel.vd               = req_vd[grant_idx*VD_W +: VD_W];
      sel.mask             = req_mask[grant_idx*MASK_W +: MASK_W];
      sel.data             = req_data[grant_idx*DATA_W +: DATA_W];
      sel.last             = req_last[grant_idx];
      sel.instructionIndex = req_instructionIndex[grant_idx*IDX_W +: IDX_W];
      load                 = accept & ((|sel.mask) | sel.last);
      deq                  = full_q & vrfWrite_ready;
      full_d               = load | (full_q & ~vrfWrite_ready);
      bits_d               = load ? sel : bits_q;
      slot_d               = load ? grant_idx : slot_q;
      retire_d             = deq & bits_q.last;
      ret_idx_d            = retire_d ? bits_q.instructionIndex : ret_idx_q;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         full_q    <= 1'b0;
         bits_q    <= '0;
         slot_q    <= '0;
         retire_q  <= 1'b0;
         ret_idx_q <= '0;
      end else begin
         full_q    <= full_d;
         bits_q    <= bits_d;
         slot_q    <= slot_d;
         retire_q  <= retire_d;
         ret_idx_q <= ret_idx_d;
      end
   end

   assign vrfWrite_valid                 = full_q;
   assign vrfWrite_bits_vd               = bits_q.vd;
   assign vrfWrite_bits_mask             = bits_q.mask;
   assign vrfWrite_bits_data             = bits_q.data;
   assign vrfWrite_bits_last             = bits_q.last;
   assign vrfWrite_bits_instructionIndex = bits_q.instructionIndex;
   assign vrfWrite_slot                  = slot_q;
   assign retire_valid                   = retire_q;
   assign retire_instructionIndex        = ret_idx_q;

endmodule
